// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-cycle-latency RAM between a CPU (read/write)
// and a video fetcher (read-only), with round-robin priority on conflict.
module ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wstrb,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  output logic [DATA_W-1:0]     vid_rdata,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic {PORT_CPU = 1'b0, PORT_VID = 1'b1} port_t;

  port_t             last_reg;
  port_t             owner_reg;
  logic              is_read_reg;
  logic [15:0]       conflict_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic [DATA_W-1:0] vid_rdata_reg;
  logic              conflict;

  always_comb begin
    conflict = cpu_req & vid_req;
    cpu_gnt  = 1'b0;
    vid_gnt  = 1'b0;
    if (!i_rst) begin
      if (cpu_req && (!vid_req || last_reg == PORT_VID)) begin
        cpu_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end
    end
  end

  assign ram_en       = cpu_gnt | vid_gnt;
  assign ram_addr     = vid_gnt ? vid_addr : cpu_addr;
  assign ram_we       = (cpu_gnt && cpu_we) ? cpu_wstrb : '0;
  assign ram_wdata    = cpu_wdata;
  assign conflict_cnt = conflict_reg;

  // Reset gating also kills a response whose grant happened just before reset.
  assign cpu_rvalid = !i_rst && is_read_reg && (owner_reg == PORT_CPU);
  assign vid_rvalid = !i_rst && is_read_reg && (owner_reg == PORT_VID);

  // Read data passes straight through in the valid cycle and is held afterwards.
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_reg;
  assign vid_rdata = vid_rvalid ? ram_rdata : vid_rdata_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_reg      <= PORT_VID;
      owner_reg     <= PORT_CPU;
      is_read_reg   <= 1'b0;
      conflict_reg  <= 16'd0;
      cpu_rdata_reg <= '0;
      vid_rdata_reg <= '0;
    end else begin
      if (cpu_gnt) begin
        last_reg <= PORT_CPU;
      end else if (vid_gnt) begin
        last_reg <= PORT_VID;
      end
      owner_reg   <= vid_gnt ? PORT_VID : PORT_CPU;
      is_read_reg <= vid_gnt | (cpu_gnt & ~cpu_we);
      if (conflict && conflict_reg != 16'hFFFF) begin
        conflict_reg <= conflict_reg + 16'd1;
      end
      if (cpu_rvalid) begin
        cpu_rdata_reg <= ram_rdata;
      end
      if (vid_rvalid) begin
        vid_rdata_reg <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, golden memory and a
// response scoreboard checked once per cycle.
module tb_ram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt, vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [15:0]       conflict_cnt;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        owner;   // 0 = CPU, 1 = video
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] gold[int];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic logic [31:0] pattern(int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] gold_rd(int a);
    if (gold.exists(a)) return gold[a];
    return pattern(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check responses due now and this cycle's grant, then advance.
  task automatic tick(input logic ec, input logic ev);
    logic        exp_cv, exp_vv;
    logic [31:0] exp_d, merged;
    resp_t       r;
    @(negedge clk);
    exp_cv = 1'b0; exp_vv = 1'b0; exp_d = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_cv = !r.owner;
      exp_vv = r.owner;
      exp_d  = r.data;
    end
    chk("cpu_rvalid", cpu_rvalid, exp_cv);
    chk("vid_rvalid", vid_rvalid, exp_vv);
    if (exp_cv) chk("cpu_rdata", cpu_rdata, exp_d);
    if (exp_vv) chk("vid_rdata", vid_rdata, exp_d);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("vid_gnt", vid_gnt, ev);
    chk("ram_en", ram_en, ec | ev);
    chk("ram_we", ram_we, (ec && cpu_we) ? cpu_wstrb : 4'h0);
    chk("ram_wdata", ram_wdata, cpu_wdata);
    if (ec) chk("ram_addr_cpu", ram_addr, cpu_addr);
    if (ev) chk("ram_addr_vid", ram_addr, vid_addr);
    if (ec && !cpu_we) exp_q.push_back('{1'b0, gold_rd(int'(cpu_addr)), cyc + 1});
    if (ev)            exp_q.push_back('{1'b1, gold_rd(int'(vid_addr)), cyc + 1});
    if (ec && cpu_we) begin
      merged = gold_rd(int'(cpu_addr));
      for (int b = 0; b < 4; b++) begin
        if (cpu_wstrb[b]) merged[b*8 +: 8] = cpu_wdata[b*8 +: 8];
      end
      gold[int'(cpu_addr)] = merged;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    exp_q.delete();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rst_conflict_cnt", conflict_cnt, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_vid_rdata", vid_rdata, 32'd0);
    i_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pattern(i);
    i_rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    vid_req = 1'b0; vid_addr = '0;
    #1;

    // Reset with both requesting: nothing granted, nothing counted.
    cpu_req = 1'b1; vid_req = 1'b1;
    do_reset();
    cpu_req = 1'b0; vid_req = 1'b0;

    // Lone CPU read of 0x400.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h400;
    tick(1'b1, 1'b0);
    cpu_req = 1'b0;
    tick(1'b0, 1'b0);

    // CPU write 0xDEADBEEF, then two back-to-back video reads.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'hF;
    tick(1'b1, 1'b0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    vid_req = 1'b1; vid_addr = 14'h400;
    tick(1'b0, 1'b1);
    vid_addr = 14'h401;
    tick(1'b0, 1'b1);
    vid_req = 1'b0;
    tick(1'b0, 1'b0);
    chk("cpu_rdata_hold", cpu_rdata, pattern(14'h400));

    // Partial-strobe CPU write: no read response, then read it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h123;
    cpu_wdata = 32'h1122_3344; cpu_wstrb = 4'h3;
    tick(1'b1, 1'b0);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wstrb = 4'h0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    cpu_req = 1'b1;
    tick(1'b1, 1'b0);
    cpu_req = 1'b0;
    tick(1'b0, 1'b0);
    chk("vid_rdata_hold", vid_rdata, pattern(14'h401));

    // Six cycles of conflict right after reset: C,V,C,V,C,V.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 14'h010; vid_req = 1'b1; vid_addr = 14'h020;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    tick(1'b0, 1'b0);
    chk("conflict_cnt_6", conflict_cnt, 32'd6);

    // Video read, then reset the next cycle: its response must be dropped.
    vid_req = 1'b1; vid_addr = 14'h030;
    tick(1'b0, 1'b1);
    vid_req = 1'b0;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 14'h031; vid_req = 1'b1;
    tick(1'b1, 1'b0);
    cpu_req = 1'b0; vid_req = 1'b0;
    tick(1'b0, 1'b0);

    // Saturation of the conflict counter.
    do_reset();
    cpu_req = 1'b1; vid_req = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("conflict_cnt_fffe", conflict_cnt, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("conflict_cnt_sat", conflict_cnt, 32'h0000_FFFF);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; the byte-strobe width SHALL be DATA_W/8.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
  i_clk  in  1  clock; all state updates on its rising edge
  i_rst  in  1  synchronous active-high reset
  cpu_req  in  1  CPU access request
  cpu_we  in  1  1=write, 0=read
  cpu_addr  in  ADDR_W  CPU word address
  cpu_wdata  in  DATA_W  CPU write data
  cpu_wstrb  in  DATA_W/8  CPU byte enables for writes
  cpu_gnt  out  1  CPU access accepted this cycle
  cpu_rvalid  out  1  CPU read data valid
  cpu_rdata  out  DATA_W  CPU read data
  vid_req  in  1  video fetch request (read-only)
  vid_addr  in  ADDR_W  video word address
  vid_gnt  out  1  video access accepted this cycle
  vid_rvalid  out  1  video read data valid
  vid_rdata  out  DATA_W  video read data
  ram_en  out  1  RAM access strobe
  ram_we  out  DATA_W/8  RAM byte write enables
  ram_addr  out  ADDR_W  RAM word address
  ram_wdata  out  DATA_W  RAM write data
  ram_rdata  in  DATA_W  RAM read data; valid one cycle after a read strobe
  conflict_cnt  out  16  count of cycles in which both ports requested

Function
REQ-005 The block SHALL grant at most one port per cycle: cpu_gnt and vid_gnt SHALL never both be 1.
REQ-006 A grant SHALL be combinational in the requesting cycle: a lone requester SHALL be granted in the same cycle it requests.
REQ-007 On conflict (cpu_req and vid_req both 1), the grant SHALL go to the port that is not recorded in the last-granted register (last).
REQ-008 last SHALL update to the granted port on every granted cycle and SHALL hold when nothing is granted.
REQ-009 In a granted cycle, ram_en SHALL be 1 and ram_addr SHALL equal the winner's address; ram_en SHALL be 0 otherwise.
REQ-010 ram_we SHALL equal cpu_wstrb when the CPU is granted with cpu_we=1, and SHALL be 0 in every other case, including all video grants.
REQ-011 ram_wdata SHALL equal cpu_wdata.
REQ-012 A granted read SHALL produce exactly one rvalid pulse to its owner, one cycle after the grant, with rdata equal to ram_rdata in that cycle.
REQ-013 A granted write SHALL produce no rvalid.
REQ-014 The block SHALL track response ownership in a registered pipeline stage (owner, is_read).
REQ-015 Back-to-back grants SHALL be sustained every cycle, giving full throughput with one response per cycle.
REQ-016 A non-owner's rvalid SHALL be 0. A non-owner's rdata SHALL hold its previous value; it is not required to be 0.
REQ-017 Requesters SHALL hold req and address stable until granted; the block is not required to handle a request dropped before grant.
REQ-018 conflict_cnt SHALL increment by 1 in each cycle where both requests are 1, and SHALL saturate at 0xFFFF.
REQ-019 Under continuous dual requests, grants SHALL strictly alternate, so the maximum wait of either port is 1 cycle.

Reset
REQ-020 While i_rst=1: gnt, rvalid, ram_en and ram_we outputs SHALL be 0; conflict_cnt SHALL be 0; last SHALL be VID, so the CPU wins the first conflict; the response pipeline SHALL be cleared.
REQ-021 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.
REQ-022 rdata registers SHALL reset to 0.

Verification
REQ-023 The bench SHALL cover these scenarios:
  - Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x400 alone -> cpu_gnt=1 and ram_addr=0x400 in the same cycle; next cycle cpu_rvalid=1 and cpu_rdata=ram_rdata.
  - CPU write to 0x400, wdata 0xDEADBEEF, wstrb 0xF, then a video read of 0x400 -> ram_we=0xF in cycle 1; vid_rvalid=1 and vid_rdata=0xDEADBEEF in cycle 3.
  - Both requesting for 6 cycles starting right after reset -> grant order C,V,C,V,C,V; conflict_cnt=6; no cycle has both gnt=1.
  - CPU write with wstrb=0x3 while video idle -> ram_we=0x3, with no cpu_rvalid afterwards.
  - Video read granted, then i_rst pulsed the next cycle -> vid_rvalid stays 0; after reset, a conflict is won by the CPU.
  - Force conflict_cnt near 0xFFFF and hold conflicts for 3 cycles -> conflict_cnt stays at 0xFFFF.
